// File: rtl/oam_dma_arbiter_pkg.sv
// rtl/oam_dma_arbiter_pkg.sv - shared state encodings, bus constants and decode helper for the OAM DMA arbiter
package oam_dma_arbiter_pkg;

   // Arbiter states. IDLE is all-zero so a cleared register means "CPU owns the bus".
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HALT  = 3'd1,
      ST_ALIGN = 3'd2,
      ST_READ  = 3'd3,
      ST_WRITE = 3'd4
   } dma_state_t;

   // Default CPU register that kicks off a transfer.
   localparam logic [15:0] DMA_REG_ADDR_DEFAULT  = 16'h4014;

   // Default destination of every DMA write (sprite data port).
   localparam logic [15:0] OAM_DATA_ADDR_DEFAULT = 16'h2004;

   // Bus direction values.
   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   // Final byte index of a 256-byte page.
   localparam logic [7:0] LAST_BYTE = 8'hFF;

   // Data driven onto the write bus during DMA read cycles.
   localparam logic [7:0] IDLE_DATA = 8'h00;

   // True when the CPU is writing the DMA trigger register this cycle.
   function automatic logic is_trigger(input logic [15:0] addr,
                                       input logic        rw,
                                       input logic [15:0] reg_addr);
      return (rw == RW_WRITE) && (addr == reg_addr);
   endfunction

endpackage

// File: rtl/oam_dma_arbiter.sv
// rtl/oam_dma_arbiter.sv - bus arbiter that halts the CPU and copies one 256-byte page to the OAM data port
module oam_dma_arbiter
   import oam_dma_arbiter_pkg::*;
#(
   parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEFAULT,
   parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_data_out,
   input  logic        cpu_rw,
   input  logic [7:0]  bus_data_in,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_data_out,
   output logic        bus_rw,
   output logic        cpu_rdy,
   output logic        dma_active
);

   dma_state_t  state;
   dma_state_t  next_state;
   logic [7:0]  page;
   logic [7:0]  counter;
   logic [7:0]  data_latch;
   logic        parity;
   logic        trigger;

   // CPU bus is only decoded while the CPU owns the bus; anything it does mid-transfer is dropped.
   assign trigger = (state == ST_IDLE) && is_trigger(cpu_addr, cpu_rw, DMA_REG_ADDR);

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: HALT waits one extra cycle when needed so every READ lands on a parity-0 cycle.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:  next_state = trigger ? ST_HALT : ST_IDLE;
         ST_HALT:  next_state = parity ? ST_READ : ST_ALIGN;
         ST_ALIGN: next_state = ST_READ;
         ST_READ:  next_state = ST_WRITE;
         ST_WRITE: next_state = (counter == LAST_BYTE) ? ST_IDLE : ST_READ;
         default:  next_state = ST_IDLE;
      endcase
   end

   // Transfer datapath: parity, page latch, byte counter and the byte in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         parity     <= 1'b0;
         page       <= 8'h00;
         counter    <= 8'h00;
         data_latch <= 8'h00;
      end else begin
         parity <= ~parity;
         if (trigger) begin
            page    <= cpu_data_out;
            counter <= 8'h00;
         end
         if (state == ST_READ) begin
            data_latch <= bus_data_in;
         end
         if (state == ST_WRITE) begin
            counter <= counter + 8'd1;
         end
      end
   end

   // Registered status flags, aligned with the state they describe.
   always_ff @(posedge clock) begin
      if (reset) begin
         cpu_rdy    <= 1'b1;
         dma_active <= 1'b0;
      end else begin
         cpu_rdy    <= (next_state == ST_IDLE);
         dma_active <= (next_state != ST_IDLE);
      end
   end

   // Bus mux: CPU pass-through in IDLE and while reset is held, so an aborted transfer issues no more cycles.
   always_comb begin
      bus_addr     = cpu_addr;
      bus_data_out = cpu_data_out;
      bus_rw       = cpu_rw;
      if (!reset) begin
         case (state)
            ST_HALT, ST_ALIGN: begin
               bus_addr     = cpu_addr;
               bus_data_out = IDLE_DATA;
               bus_rw       = RW_READ;
            end
            ST_READ: begin
               bus_addr     = {page, counter};
               bus_data_out = IDLE_DATA;
               bus_rw       = RW_READ;
            end
            ST_WRITE: begin
               bus_addr     = OAM_DATA_ADDR;
               bus_data_out = data_latch;
               bus_rw       = RW_WRITE;
            end
            default: begin
               bus_addr     = cpu_addr;
               bus_data_out = cpu_data_out;
               bus_rw       = cpu_rw;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// tb/tb_oam_dma_arbiter.sv - directed self-checking bench for the OAM DMA arbiter
module tb_oam_dma_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_data_out;
   logic        cpu_rw;
   logic [7:0]  bus_data_in;
   logic [15:0] bus_addr;
   logic [7:0]  bus_data_out;
   logic        bus_rw;
   logic        cpu_rdy;
   logic        dma_active;

   int checks = 0;
   int fails  = 0;

   logic       tb_par;
   logic [7:0] wr_data [0:255];
   int busy_n, dummy_n, read_n, write_n;
   int bad_addr_n, bad_par_n, bad_do_n, bad_act_n;

   oam_dma_arbiter dut (
      .clock        (clock),
      .reset        (reset),
      .cpu_addr     (cpu_addr),
      .cpu_data_out (cpu_data_out),
      .cpu_rw       (cpu_rw),
      .bus_data_in  (bus_data_in),
      .bus_addr     (bus_addr),
      .bus_data_out (bus_data_out),
      .bus_rw       (bus_rw),
      .cpu_rdy      (cpu_rdy),
      .dma_active   (dma_active)
   );

   // System memory contents seen on reads.
   function automatic logic [7:0] mem_rd(input logic [15:0] a);
      if (a[15:8] == 8'h03) return a[7:0] ^ 8'h5A;
      else if (a[15:8] == 8'h02) return a[7:0] + 8'h01;
      else return 8'h77;
   endfunction

   assign bus_data_in = mem_rd(bus_addr);

   always #5 clock = ~clock;

   // Free-running parity reference: 0 in reset, toggles every cycle.
   always @(posedge clock) tb_par <= reset ? 1'b0 : ~tb_par;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle_drive();
      cpu_addr     = 16'hC123;
      cpu_data_out = 8'hEE;
      cpu_rw       = 1'b1;
   endtask

   // Issue a CPU write of pg to 4014 in a cycle whose parity equals par.
   task automatic trigger(input logic [7:0] pg, input logic par);
      int guard = 0;
      @(posedge clock); #1;
      while (tb_par !== par && guard < 4) begin
         @(posedge clock); #1;
         guard++;
      end
      cpu_addr     = 16'h4014;
      cpu_rw       = 1'b0;
      cpu_data_out = pg;
      @(negedge clock);
      checks++;
      if (bus_addr !== 16'h4014 || bus_rw !== 1'b0 || bus_data_out !== pg || cpu_rdy !== 1'b1) begin
         fails++;
         $display("FAIL trigger_passthrough: got addr=%h rw=%b data=%h rdy=%b, expected 4014/0/%h/1",
                  bus_addr, bus_rw, bus_data_out, cpu_rdy, pg);
      end
      @(posedge clock); #1;
      idle_drive();
   endtask

   // Observe one transfer from first stalled cycle to return of cpu_rdy.
   task automatic measure(input logic [7:0] pg, input bit inject, input bit chain, input logic [7:0] chain_pg);
      bit started = 0;
      bit done    = 0;
      busy_n = 0; dummy_n = 0; read_n = 0; write_n = 0;
      bad_addr_n = 0; bad_par_n = 0; bad_do_n = 0; bad_act_n = 0;
      for (int cyc = 0; cyc < 1200 && !done; cyc++) begin
         @(negedge clock);
         if (cpu_rdy === 1'b0) begin
            started = 1;
            busy_n++;
            if (dma_active !== 1'b1) bad_act_n++;
            if (bus_rw === 1'b1) begin
               if (bus_data_out !== 8'h00) bad_do_n++;
               if (bus_addr === 16'hC123 && read_n == 0) begin
                  dummy_n++;
               end else begin
                  if (bus_addr !== {pg, read_n[7:0]}) bad_addr_n++;
                  if (tb_par !== 1'b0) bad_par_n++;
                  read_n++;
               end
            end else begin
               if (bus_addr === 16'h2004) begin
                  if (write_n < 256) wr_data[write_n] = bus_data_out;
                  write_n++;
               end else begin
                  bad_addr_n++;
               end
            end
            if (inject) begin
               if (busy_n == 100) begin
                  cpu_addr     = 16'h4014;
                  cpu_rw       = 1'b0;
                  cpu_data_out = 8'h07;
               end
               if (busy_n == 104) idle_drive();
            end
         end else if (started) begin
            done = 1;
            if (chain) begin
               cpu_addr     = 16'h4014;
               cpu_rw       = 1'b0;
               cpu_data_out = chain_pg;
            end
         end
      end
      if (chain && done) begin
         @(posedge clock); #1;
         idle_drive();
      end
      checks++;
      if (!done) begin
         fails++;
         $display("FAIL transfer_timeout: got started=%0d done=%0d, expected transfer to complete", started, done);
      end
   endtask

   task automatic check_transfer(input string name, input logic [7:0] pg, input int exp_busy, input int exp_dummy);
      int bad_data = 0;
      logic [7:0] exp;
      checks++;
      if (busy_n != exp_busy) begin
         fails++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_n, exp_busy);
      end
      checks++;
      if (dummy_n != exp_dummy) begin
         fails++; $display("FAIL %s dummy_reads: got %0d expected %0d", name, dummy_n, exp_dummy);
      end
      checks++;
      if (read_n != 256 || write_n != 256) begin
         fails++; $display("FAIL %s pair_count: got reads=%0d writes=%0d expected 256/256", name, read_n, write_n);
      end
      checks++;
      if (bad_addr_n != 0 || bad_par_n != 0) begin
         fails++; $display("FAIL %s read_addr_parity: got bad_addr=%0d bad_par=%0d expected 0/0", name, bad_addr_n, bad_par_n);
      end
      checks++;
      if (bad_do_n != 0 || bad_act_n != 0) begin
         fails++; $display("FAIL %s read_data_active: got bad_do=%0d bad_active=%0d expected 0/0", name, bad_do_n, bad_act_n);
      end
      for (int i = 0; i < 256; i++) begin
         exp = (pg == 8'h03) ? (i[7:0] ^ 8'h5A) : (i[7:0] + 8'h01);
         if (wr_data[i] !== exp) bad_data++;
      end
      checks++;
      if (bad_data != 0) begin
         fails++; $display("FAIL %s write_data: got %0d wrong bytes expected 0", name, bad_data);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_drive();
      repeat (3) @(posedge clock);
      @(negedge clock);
      checks++;
      if (cpu_rdy !== 1'b1 || dma_active !== 1'b0) begin
         fails++; $display("FAIL reset_flags: got rdy=%b active=%b expected 1/0", cpu_rdy, dma_active);
      end
      checks++;
      if (bus_addr !== 16'hC123 || bus_rw !== 1'b1 || bus_data_out !== 8'hEE) begin
         fails++; $display("FAIL reset_passthrough: got %h/%b/%h expected c123/1/ee", bus_addr, bus_rw, bus_data_out);
      end
      cpu_addr = 16'h4014; cpu_rw = 1'b0; cpu_data_out = 8'h09;
      @(posedge clock); #1;
      reset = 1'b0;
      idle_drive();
      @(negedge clock);
      checks++;
      if (dma_active !== 1'b0 || cpu_rdy !== 1'b1) begin
         fails++; $display("FAIL reset_trigger_ignored: got active=%b rdy=%b expected 0/1", dma_active, cpu_rdy);
      end
   endtask

   task automatic test_passthrough();
      @(posedge clock); #1;
      cpu_addr = 16'h4015; cpu_rw = 1'b0; cpu_data_out = 8'h11;
      @(negedge clock);
      checks++;
      if (bus_addr !== 16'h4015 || bus_rw !== 1'b0 || bus_data_out !== 8'h11 || cpu_rdy !== 1'b1 || dma_active !== 1'b0) begin
         fails++; $display("FAIL pass_write: got %h/%b/%h rdy=%b act=%b expected 4015/0/11 1/0",
                           bus_addr, bus_rw, bus_data_out, cpu_rdy, dma_active);
      end
      @(posedge clock); #1;
      cpu_addr = 16'h8000; cpu_rw = 1'b1; cpu_data_out = 8'h00;
      @(negedge clock);
      checks++;
      if (bus_addr !== 16'h8000 || bus_rw !== 1'b1 || cpu_rdy !== 1'b1 || dma_active !== 1'b0) begin
         fails++; $display("FAIL pass_read: got %h/%b rdy=%b act=%b expected 8000/1 1/0", bus_addr, bus_rw, cpu_rdy, dma_active);
      end
      @(posedge clock); #1;
      idle_drive();
      repeat (2) @(negedge clock);
      checks++;
      if (dma_active !== 1'b0 || cpu_rdy !== 1'b1) begin
         fails++; $display("FAIL pass_no_dma: got act=%b rdy=%b expected 0/1", dma_active, cpu_rdy);
      end
   endtask

   task automatic test_parity_one();
      trigger(8'h02, 1'b1);
      measure(8'h02, 0, 0, 8'h00);
      check_transfer("parity_one", 8'h02, 514, 2);
   endtask

   task automatic test_parity_zero();
      trigger(8'h02, 1'b0);
      measure(8'h02, 0, 0, 8'h00);
      check_transfer("parity_zero", 8'h02, 513, 1);
   endtask

   task automatic test_page_data();
      trigger(8'h03, 1'b0);
      measure(8'h03, 0, 0, 8'h00);
      check_transfer("page_data", 8'h03, 513, 1);
      checks++;
      if (wr_data[0] !== 8'h5A || wr_data[1] !== 8'h5B || wr_data[255] !== 8'hA5) begin
         fails++; $display("FAIL page_data_edges: got %h %h %h expected 5a 5b a5", wr_data[0], wr_data[1], wr_data[255]);
      end
   endtask

   task automatic test_dropped_write();
      trigger(8'h03, 1'b1);
      measure(8'h03, 1, 0, 8'h00);
      check_transfer("dropped_write", 8'h03, 514, 2);
      repeat (4) @(negedge clock);
      checks++;
      if (cpu_rdy !== 1'b1 || dma_active !== 1'b0) begin
         fails++; $display("FAIL dropped_write_no_retrigger: got rdy=%b act=%b expected 1/0", cpu_rdy, dma_active);
      end
   endtask

   task automatic test_back_to_back();
      trigger(8'h03, 1'b0);
      measure(8'h03, 0, 1, 8'h02);
      check_transfer("b2b_first", 8'h03, 513, 1);
      measure(8'h02, 0, 0, 8'h00);
      check_transfer("b2b_second", 8'h02, 513, 1);
   endtask

   task automatic test_reset_abort();
      bit found = 0;
      int stray = 0;
      trigger(8'h03, 1'b0);
      for (int cyc = 0; cyc < 1000 && !found; cyc++) begin
         @(negedge clock);
         if (cpu_rdy === 1'b0 && bus_rw === 1'b1 && bus_addr === 16'h0380) found = 1;
      end
      checks++;
      if (!found) begin
         fails++; $display("FAIL abort_reach_byte80: got found=0 expected 1");
      end
      @(posedge clock); #1;
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (bus_addr !== 16'hC123 || bus_rw !== 1'b1) begin
         fails++; $display("FAIL abort_reset_passthrough: got %h/%b expected c123/1", bus_addr, bus_rw);
      end
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if (cpu_rdy !== 1'b1 || dma_active !== 1'b0) begin
         fails++; $display("FAIL abort_idle: got rdy=%b act=%b expected 1/0", cpu_rdy, dma_active);
      end
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clock);
         if (bus_rw !== 1'b1 || cpu_rdy !== 1'b1 || bus_addr !== 16'hC123) stray++;
      end
      checks++;
      if (stray != 0) begin
         fails++; $display("FAIL abort_no_more_dma: got %0d stray cycles expected 0", stray);
      end
      trigger(8'h03, 1'b0);
      measure(8'h03, 0, 0, 8'h00);
      check_transfer("after_abort", 8'h03, 513, 1);
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_parity_one();
      test_parity_zero();
      test_page_data();
      test_dropped_write();
      test_back_to_back();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
